// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
// that owns the architectural HI/LO registers and talks to the pipeline over a
// valid/ready handshake.  Multiply is radix-2 shift-add and divide is restoring
// division.  Both run on operand magnitudes and fix the signs in a final DONE cycle.
// Optional build macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle
// combinational multiplier and complete on the accepting edge.
module mul_div_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] src1,
    input  logic [W-1:0] src2,
    input  logic         cancel,
    output logic         busy,
    output logic         res_valid,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int            CW       = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Absolute value of x when sgn is set, otherwise x unchanged.
    function automatic logic [W-1:0] mag_of(input logic [W-1:0] x, input logic sgn);
        logic [W-1:0] r;
        if (sgn && x[W-1]) begin
            r = ~x + W'(1);
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Two's-complement negate a W-bit value when en is set.
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
        logic [W-1:0] r;
        if (en) begin
            r = ~x + W'(1);
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Two's-complement negate a 2W-bit value when en is set.
    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
        logic [2*W-1:0] r;
        if (en) begin
            r = ~x + (2*W)'(1);
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    // MUL: {accumulator, multiplier}; DIV: {partial remainder, dividend/quotient}
    logic [2*W-1:0] work_r, work_s;
    // Multiplicand magnitude (MUL) or divisor magnitude (DIV)
    logic [W-1:0]   opnd_r, opnd_s;
    logic [W-1:0]   dividend_r, dividend_s;
    logic           is_div_r, is_div_s;
    logic           neg_q_r, neg_q_s;
    logic           neg_rem_r, neg_rem_s;
    logic           div_zero_r, div_zero_s;
    logic [W-1:0]   hi_r, hi_s;
    logic [W-1:0]   lo_r, lo_s;
    logic           res_valid_r, res_valid_s;
    logic           op_ready_r;
    logic           busy_r;

    logic           accept_s;
    logic           mul_signed_s;
    logic           div_signed_s;
    logic [W:0]     mul_sum_s;
    logic [2*W-1:0] mul_next_s;
    logic [W:0]     div_shift_s;
    logic           div_ge_s;
    logic [W-1:0]   div_rem_s;
    logic [2*W-1:0] div_next_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s;
    logic [W-1:0]   rem_s;
    logic [W-1:0]   res_hi_s;
    logic [W-1:0]   res_lo_s;

    assign hi        = hi_r;
    assign lo        = lo_r;
    assign res_valid = res_valid_r;
    assign op_ready  = op_ready_r;
    assign busy      = busy_r;

    // Request acceptance and operand signedness decode
    always_comb begin
        accept_s     = op_valid & (state_r == ST_IDLE) & ~cancel;
        mul_signed_s = (op == OP_MULT);
        div_signed_s = (op == OP_DIV);
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_a_s;
    logic [2*W-1:0] fast_b_s;
    logic [2*W-1:0] fast_prod_s;

    // Single-cycle product: extend to 2W bits so the truncated product is exact
    always_comb begin
        if (mul_signed_s) begin
            fast_a_s = {{W{src1[W-1]}}, src1};
            fast_b_s = {{W{src2[W-1]}}, src2};
        end else begin
            fast_a_s = {{W{1'b0}}, src1};
            fast_b_s = {{W{1'b0}}, src2};
        end
        fast_prod_s = fast_a_s * fast_b_s;
    end
`endif

    // One iteration step of shift-add multiply and of restoring divide
    always_comb begin
        if (work_r[0]) begin
            mul_sum_s = {1'b0, work_r[2*W-1:W]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, work_r[2*W-1:W]};
        end
        mul_next_s  = {mul_sum_s, work_r[W-1:1]};
        // Partial remainder is always below the divisor, so the shifted value
        // fits in W+1 bits and the selected next remainder fits in W bits.
        div_shift_s = {work_r[2*W-1:W], work_r[W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        if (div_ge_s) begin
            div_rem_s = div_shift_s[W-1:0] - opnd_r;
        end else begin
            div_rem_s = div_shift_s[W-1:0];
        end
        div_next_s  = {div_rem_s, work_r[W-2:0], div_ge_s};
    end

    // Final sign correction of the magnitude result, applied while in DONE
    always_comb begin
        prod_s = neg_2w(work_r, neg_q_r);
        quo_s  = neg_w(work_r[W-1:0], neg_q_r);
        rem_s  = neg_w(work_r[2*W-1:W], neg_rem_r);
        if (!is_div_r) begin
            res_hi_s = prod_s[2*W-1:W];
            res_lo_s = prod_s[W-1:0];
        end else if (div_zero_r) begin
            res_hi_s = dividend_r;
            res_lo_s = {W{1'b1}};
        end else begin
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end
    end

    // Next-state logic; cancel always returns the unit to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op)
`ifdef MDU_FAST_MUL_EN
                        OP_MULT, OP_MULTU: state_s = ST_IDLE;
`else
                        OP_MULT, OP_MULTU: state_s = ST_MUL;
`endif
                        OP_DIV, OP_DIVU:   state_s = ST_DIV;
                        default:           state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath next values: operand capture, iteration, HI/LO writes
    always_comb begin
        cnt_s       = cnt_r;
        work_s      = work_r;
        opnd_s      = opnd_r;
        dividend_s  = dividend_r;
        is_div_s    = is_div_r;
        neg_q_s     = neg_q_r;
        neg_rem_s   = neg_rem_r;
        div_zero_s  = div_zero_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        res_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                            hi_s        = fast_prod_s[2*W-1:W];
                            lo_s        = fast_prod_s[W-1:0];
                            res_valid_s = 1'b1;
`else
                            opnd_s     = mag_of(src1, mul_signed_s);
                            work_s     = {{W{1'b0}}, mag_of(src2, mul_signed_s)};
                            neg_q_s    = mul_signed_s & (src1[W-1] ^ src2[W-1]);
                            neg_rem_s  = 1'b0;
                            is_div_s   = 1'b0;
                            div_zero_s = 1'b0;
                            cnt_s      = {CW{1'b0}};
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            opnd_s     = mag_of(src2, div_signed_s);
                            work_s     = {{W{1'b0}}, mag_of(src1, div_signed_s)};
                            neg_q_s    = div_signed_s & (src1[W-1] ^ src2[W-1]);
                            neg_rem_s  = div_signed_s & src1[W-1];
                            dividend_s = src1;
                            div_zero_s = (src2 == {W{1'b0}});
                            is_div_s   = 1'b1;
                            cnt_s      = {CW{1'b0}};
                        end
                        OP_MTHI: begin
                            hi_s        = src1;
                            res_valid_s = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_s        = src1;
                            res_valid_s = 1'b1;
                        end
                        default: res_valid_s = 1'b0;
                    endcase
                end else begin
                    res_valid_s = 1'b0;
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    cnt_s = {CW{1'b0}};
                end else begin
                    work_s = mul_next_s;
                    cnt_s  = cnt_r + CW'(1);
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    cnt_s = {CW{1'b0}};
                end else begin
                    work_s = div_next_s;
                    cnt_s  = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                cnt_s = {CW{1'b0}};
                if (!cancel) begin
                    hi_s        = res_hi_s;
                    lo_s        = res_lo_s;
                    res_valid_s = 1'b1;
                end else begin
                    res_valid_s = 1'b0;
                end
            end
            default: cnt_s = {CW{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CW{1'b0}};
            work_r      <= {(2*W){1'b0}};
            opnd_r      <= {W{1'b0}};
            dividend_r  <= {W{1'b0}};
            is_div_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            div_zero_r  <= 1'b0;
            hi_r        <= {W{1'b0}};
            lo_r        <= {W{1'b0}};
            res_valid_r <= 1'b0;
            op_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            work_r      <= work_s;
            opnd_r      <= opnd_s;
            dividend_r  <= dividend_s;
            is_div_r    <= is_div_s;
            neg_q_r     <= neg_q_s;
            neg_rem_r   <= neg_rem_s;
            div_zero_r  <= div_zero_s;
            hi_r        <= hi_s;
            lo_r        <= lo_s;
            res_valid_r <= res_valid_s;
            op_ready_r  <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit that extends the CPU's single-cycle integer ALU with MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO. Owns the architectural HI/LO registers and sits beside the ALU in the execute stage. Uses a valid/ready handshake, so the pipeline stalls while the unit is busy. Supports cancellation on exception flush.

Parameters:
W, 32, operand width in bits (even, >= 8); HI and LO are each W bits, and the iteration counter width is derived as clog2(W)+1.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  request present
op_ready  output  1  unit can accept a request; equals (state==IDLE)
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
src1  input  W  rs operand (dividend / multiplicand / MTHI-MTLO data)
src2  input  W  rt operand (divisor / multiplier)
cancel  input  1  flush: abort any operation in flight
busy  output  1  state != IDLE
res_valid  output  1  one-cycle pulse: HI/LO just updated by a completed op
hi  output  W  HI register
lo  output  W  LO register

Behaviour:
- Reset (asynchronous): state=IDLE; hi=0, lo=0, res_valid=0, busy=0, counter=0. op_ready=1 once reset deasserts.
- Accept: a request is accepted on an edge where op_valid & op_ready & ~cancel. Inputs are sampled only at acceptance, so later input changes are ignored.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - MULT/MULTU -> MUL. DIV/DIVU -> DIV. Latch operand magnitudes (absolute values if signed), result-sign flags, and the op; counter=0.
  - MTHI/MTLO: write src1 to hi/lo on the accepting edge; res_valid=1 for the following cycle; stay IDLE.
  - Reserved op: consumed, no effect, no res_valid.
- MUL: radix-2 shift-add, one bit per cycle, W cycles. Then -> DONE.
- DIV: restoring division, one quotient bit per cycle, W cycles. Then -> DONE.
- DONE (one cycle): apply sign correction; write {hi,lo} on the edge leaving DONE; res_valid=1 for the cycle after that edge; -> IDLE.
- Latency: with acceptance at edge 0, hi/lo are updated at edge W+1 and res_valid is high in cycle W+1 to W+2. op_ready is high again in that same cycle, so back-to-back issue is legal.
- Multiply result: the 2W-bit product. {hi,lo} = product. Signed: negate the magnitude product when the operand signs differ.
- Divide result: lo=quotient, hi=remainder.
  - Signed quotient sign = sign(src1)^sign(src2).
  - Signed remainder sign = sign(src1).
  - Magnitudes are computed as unsigned W-bit values.
- Divide by zero (DIV and DIVU): lo = all ones, hi = src1 (raw dividend). Still takes the full latency.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0. This falls out of the magnitude algorithm; no special case.
- cancel:
  - In any state, cancel forces IDLE on the next edge. hi/lo are unchanged and no res_valid is produced.
  - cancel in the DONE cycle also suppresses the write.
  - cancel with op_valid in IDLE: the request is not accepted (includes MTHI/MTLO).
- op_valid while busy is ignored. The requester must hold it until op_ready.
- hi/lo are readable at all times and show the old values until the write edge.

Optional Feature:
MDU_FAST_MUL_EN:
- Defined: MULT/MULTU use a single-cycle combinational W x W multiplier. {hi,lo} is written on the accepting edge, res_valid is high the next cycle, and state stays IDLE (op_ready stays 1). Division is unchanged.
- Undefined: the iterative MUL path described above, with W+1 latency.

Test Plan:
- MULT src1=0xFFFFFFFF, src2=0x00000007 -> res_valid at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF9 (1 cycle with MDU_FAST_MUL_EN).
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; op_ready low for 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/2 back-to-back -> lo=3, hi=1.
- Boundary divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- MTHI 0x12345678 -> hi updated next edge with a 1-cycle res_valid. Then DIVU with cancel at cycle 10 -> hi stays 0x12345678, no res_valid, op_ready=1 next cycle.
- Assert reset asynchronously mid-MULT (cycle 15) -> hi=lo=0, busy=0, res_valid=0 immediately, before the next clock edge.
